btb_assoc: RTL and testbench

// Set-associative branch target buffer for the fetch stage; successor of the direct-mapped BTB.

---
 rtl/btb_assoc_pkg.sv | 15 +
 rtl/btb_assoc_if.sv | 34 +++
 rtl/btb_assoc_victim_sel.sv | 25 ++
 rtl/btb_assoc.sv | 172 +++++++++++++++++
 tb/tb_btb_assoc.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_assoc_pkg.sv
// Shared configuration and types for the set-associative branch target buffer.
// Default geometry used by the interface and the top-level parameters.
package btb_assoc_pkg;

    localparam int unsigned BtbAddr     = 32;
    localparam int unsigned BtbDepth    = 32;
    localparam int unsigned BtbWay      = 2;
    localparam int unsigned BtbCntWidth = 2;

    typedef enum logic {
        IDLE,
        FLUSH
    } btb_state_t;

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-lookup, commit-training and flush signals of the branch target buffer.
// The fetch/commit side drives through master; the BTB itself uses slave.
interface btb_assoc_if
    import btb_assoc_pkg::*;
#(
    parameter int unsigned ADDR = BtbAddr
);

    logic [ADDR-1:0] pc;
    logic            btb_hit;
    logic [ADDR-1:0] btb_addr;
    logic            btb_busy;
    logic            flush_;
    logic            br_commit_;
    logic            br_taken_;
    logic            br_miss_;
    logic            jump_commit_;
    logic            jump_miss_;
    logic [ADDR-1:0] com_addr;
    logic [ADDR-1:0] com_tar_addr;

    modport master (
        output pc, flush_, br_commit_, br_taken_, br_miss_, jump_commit_, jump_miss_,
               com_addr, com_tar_addr,
        input  btb_hit, btb_addr, btb_busy
    );

    modport slave (
        input  pc, flush_, br_commit_, br_taken_, br_miss_, jump_commit_, jump_miss_,
               com_addr, com_tar_addr,
        output btb_hit, btb_addr, btb_busy
    );

endinterface

// File: rtl/btb_assoc_victim_sel.sv
// Replacement victim for one set: lowest invalid way, else the set's round-robin pointer.
// evict_o flags that the chosen way still holds a valid entry.
module btb_assoc_victim_sel #(
    parameter int unsigned WAY   = 2,
    parameter int unsigned WAY_W = 1
) (
    input  logic [WAY-1:0]   valid_i,
    input  logic [WAY_W-1:0] rr_ptr_i,
    output logic [WAY_W-1:0] victim_o,
    output logic             evict_o
);

    always_comb begin
        victim_o = rr_ptr_i;
        evict_o  = 1'b1;
        // Walk downwards so the lowest invalid way is the one left standing.
        for (int w = WAY - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o = WAY_W'(w);
                evict_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: same-cycle fetch prediction, commit-port training with saturating
// counters, per-set round-robin replacement and a one-set-per-cycle invalidation walk.
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int unsigned ADDR  = BtbAddr,
    parameter int unsigned BTB_D = BtbDepth,
    parameter int unsigned WAY   = BtbWay,
    parameter int unsigned CNT   = BtbCntWidth
) (
    input logic           clk,
    input logic           reset,
    btb_assoc_if.slave    bus
);

    localparam int unsigned SETS  = BTB_D / WAY;
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR - IDX - 2;
    localparam int unsigned WAY_W = (WAY > 1) ? $clog2(WAY) : 1;
    localparam logic [CNT-1:0] TAKEN_TH = CNT'(2 ** (CNT - 1));
    localparam logic [CNT-1:0] CNT_MAX  = {CNT{1'b1}};

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [ADDR-1:0]  target;
        logic [CNT-1:0]   cnt;
    } entry_t;

    btb_state_t       state_q, state_d;
    logic [IDX-1:0]   set_ptr_q, set_ptr_d;
    entry_t           tbl_q [SETS][WAY];
    entry_t           tbl_d [SETS][WAY];
    logic [WAY_W-1:0] rr_q [SETS];
    logic [WAY_W-1:0] rr_d [SETS];

    logic             busy;
    logic [IDX-1:0]   lk_idx, cm_idx;
    logic [TAG_W-1:0] lk_tag, cm_tag;
    logic             lk_hit, cm_hit;
    logic [WAY_W-1:0] lk_way, cm_way;
    logic [WAY-1:0]   cm_valid;
    logic [WAY_W-1:0] victim_way;
    logic             victim_evict;
    logic [WAY_W-1:0] rr_next;
    logic             jump_c, br_c, br_tk;
    logic             alloc;
    logic [CNT-1:0]   alloc_cnt;
    logic             unused_bits;

    assign busy        = (state_q == FLUSH);
    assign lk_idx      = bus.pc[IDX+1:2];
    assign lk_tag      = bus.pc[ADDR-1:IDX+2];
    assign cm_idx      = bus.com_addr[IDX+1:2];
    assign cm_tag      = bus.com_addr[ADDR-1:IDX+2];
    // Jump-miss only repeats the jump write; word-offset bits never reach the table.
    assign unused_bits = ^{bus.pc[1:0], bus.com_addr[1:0], bus.jump_miss_};

    // Lowest matching way wins if several ways ever hit.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        cm_hit = 1'b0;
        cm_way = '0;
        for (int w = WAY - 1; w >= 0; w--) begin
            cm_valid[w] = tbl_q[cm_idx][w].valid;
            if (tbl_q[lk_idx][w].valid && (tbl_q[lk_idx][w].tag == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (tbl_q[cm_idx][w].valid && (tbl_q[cm_idx][w].tag == cm_tag)) begin
                cm_hit = 1'b1;
                cm_way = WAY_W'(w);
            end
        end
    end

    btb_assoc_victim_sel #(
        .WAY   (WAY),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_i  (cm_valid),
        .rr_ptr_i (rr_q[cm_idx]),
        .victim_o (victim_way),
        .evict_o  (victim_evict)
    );

    assign rr_next = (rr_q[cm_idx] == WAY_W'(WAY - 1)) ? '0 : rr_q[cm_idx] + 1'b1;

    always_comb begin
        state_d   = state_q;
        set_ptr_d = set_ptr_q;
        tbl_d     = tbl_q;
        rr_d      = rr_q;
        alloc     = 1'b0;
        alloc_cnt = '0;
        jump_c    = !bus.jump_commit_;
        br_c      = !bus.br_commit_ && jump_c == 1'b0;
        br_tk     = !bus.br_taken_;

        unique case (state_q)
            IDLE: ;
            FLUSH: begin
                for (int w = 0; w < WAY; w++) tbl_d[set_ptr_q][w].valid = 1'b0;
                rr_d[set_ptr_q] = '0;
                if (set_ptr_q == IDX'(SETS - 1)) begin
                    state_d   = IDLE;
                    set_ptr_d = '0;
                end else begin
                    set_ptr_d = set_ptr_q + 1'b1;
                end
            end
        endcase

        if (!bus.flush_) begin
            state_d   = FLUSH;
            set_ptr_d = '0;
        end

        if (!busy) begin
            if (jump_c) begin
                if (cm_hit) begin
                    tbl_d[cm_idx][cm_way].target = bus.com_tar_addr;
                    tbl_d[cm_idx][cm_way].cnt    = CNT_MAX;
                end else begin
                    alloc     = 1'b1;
                    alloc_cnt = CNT_MAX;
                end
            end else if (br_c) begin
                if (cm_hit && br_tk) begin
                    // A mispredicted target restarts confidence at the taken threshold.
                    if (!bus.br_miss_ && (tbl_q[cm_idx][cm_way].target != bus.com_tar_addr)) begin
                        tbl_d[cm_idx][cm_way].cnt = TAKEN_TH;
                    end else if (tbl_q[cm_idx][cm_way].cnt != CNT_MAX) begin
                        tbl_d[cm_idx][cm_way].cnt = tbl_q[cm_idx][cm_way].cnt + 1'b1;
                    end
                    tbl_d[cm_idx][cm_way].target = bus.com_tar_addr;
                end else if (cm_hit) begin
                    if (tbl_q[cm_idx][cm_way].cnt != '0) begin
                        tbl_d[cm_idx][cm_way].cnt = tbl_q[cm_idx][cm_way].cnt - 1'b1;
                    end
                end else if (br_tk) begin
                    alloc     = 1'b1;
                    alloc_cnt = TAKEN_TH;
                end
            end
        end

        if (alloc) begin
            tbl_d[cm_idx][victim_way] = '{valid: 1'b1, tag: cm_tag,
                                          target: bus.com_tar_addr, cnt: alloc_cnt};
            if (victim_evict) rr_d[cm_idx] = rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FLUSH;
            set_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            set_ptr_q <= set_ptr_d;
        end
        tbl_q <= tbl_d;
        rr_q  <= rr_d;
    end

    assign bus.btb_hit  = !busy && lk_hit && (tbl_q[lk_idx][lk_way].cnt >= TAKEN_TH);
    assign bus.btb_addr = bus.btb_hit ? tbl_q[lk_idx][lk_way].target : '0;
    assign bus.btb_busy = busy;

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (32 entries, 2 ways, 2-bit counters): directed
// scenarios plus a randomized run against a behavioural table model.
module tb_btb_assoc;

    logic clk = 1'b0;
    logic reset;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    btb_assoc_if #(.ADDR(32)) bus ();

    btb_assoc #(
        .ADDR  (32),
        .BTB_D (32),
        .WAY   (2),
        .CNT   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: 16 sets x 2 ways, full-width tag, integer counter 0..3.
    typedef struct {
        bit        v;
        bit [31:0] tag;
        bit [31:0] tgt;
        int        cnt;
    } m_ent_t;

    m_ent_t m_tbl [16][2];
    int     m_rr [16];

    function automatic int m_set(input bit [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit [31:0] m_tagof(input bit [31:0] a);
        return a >> 6;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 16; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) m_tbl[s][w].v = 0;
        end
    endfunction

    function automatic void m_lookup(input bit [31:0] a, output bit hit, output bit [31:0] tgt);
        int s = m_set(a);
        hit = 0;
        tgt = 0;
        for (int w = 0; w < 2; w++) begin
            if (m_tbl[s][w].v && m_tbl[s][w].tag == m_tagof(a)) begin
                if (m_tbl[s][w].cnt >= 2) begin
                    hit = 1;
                    tgt = m_tbl[s][w].tgt;
                end
                break;
            end
        end
    endfunction

    function automatic void m_alloc(input int s, input bit [31:0] a, input bit [31:0] t,
                                    input int c);
        int vic = -1;
        for (int w = 0; w < 2; w++) if (!m_tbl[s][w].v && vic < 0) vic = w;
        if (vic < 0) begin
            vic     = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % 2;
        end
        m_tbl[s][vic].v   = 1;
        m_tbl[s][vic].tag = m_tagof(a);
        m_tbl[s][vic].tgt = t;
        m_tbl[s][vic].cnt = c;
    endfunction

    function automatic void m_commit(input bit jc, input bit bc, input bit bt, input bit bm,
                                     input bit [31:0] a, input bit [31:0] t);
        int s  = m_set(a);
        int hw = -1;
        for (int w = 0; w < 2; w++)
            if (hw < 0 && m_tbl[s][w].v && m_tbl[s][w].tag == m_tagof(a)) hw = w;
        if (jc) begin
            if (hw >= 0) begin
                m_tbl[s][hw].tgt = t;
                m_tbl[s][hw].cnt = 3;
            end else m_alloc(s, a, t, 3);
        end else if (bc) begin
            if (hw >= 0 && bt) begin
                if (bm && m_tbl[s][hw].tgt != t) m_tbl[s][hw].cnt = 2;
                else if (m_tbl[s][hw].cnt < 3) m_tbl[s][hw].cnt++;
                m_tbl[s][hw].tgt = t;
            end else if (hw >= 0) begin
                if (m_tbl[s][hw].cnt > 0) m_tbl[s][hw].cnt--;
            end else if (bt) m_alloc(s, a, t, 2);
        end
    endfunction

    task automatic release_inputs();
        bus.flush_       = 1'b1;
        bus.br_commit_   = 1'b1;
        bus.br_taken_    = 1'b1;
        bus.br_miss_     = 1'b1;
        bus.jump_commit_ = 1'b1;
        bus.jump_miss_   = 1'b1;
        bus.com_addr     = '0;
        bus.com_tar_addr = '0;
    endtask

    // One commit cycle; the model follows the same edge.
    task automatic drv_commit(input bit jc, input bit bc, input bit bt, input bit bm,
                              input bit [31:0] a, input bit [31:0] t);
        bus.jump_commit_ = !jc;
        bus.jump_miss_   = !jc;
        bus.br_commit_   = !bc;
        bus.br_taken_    = !bt;
        bus.br_miss_     = !bm;
        bus.com_addr     = a;
        bus.com_tar_addr = t;
        @(posedge clk);
        m_commit(jc, bc, bt, bm, a, t);
        #1;
        release_inputs();
    endtask

    // Measures the busy window from the current cycle; bounded at 40 cycles.
    task automatic count_busy(output int n, output bit saw_pred);
        n        = 0;
        saw_pred = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.btb_busy) break;
            n++;
            if (bus.btb_hit !== 1'b0 || bus.btb_addr !== 32'h0) saw_pred = 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int n;
        bit saw;
        release_inputs();
        bus.pc = 32'hdeadbe74;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (bus.btb_busy !== 1'b1) $display("FAIL reset_busy: busy=%b, expected 1", bus.btb_busy);
        else pass_cnt++;
        reset = 1'b0;
        m_clear();
        count_busy(n, saw);
        chk_cnt++;
        if (n != 16) $display("FAIL reset_walk_len: busy cycles=%0d, expected 16", n);
        else pass_cnt++;
        chk_cnt++;
        if (saw) $display("FAIL reset_no_pred: prediction seen=1, expected 0");
        else pass_cnt++;
        chk_cnt++;
        if (bus.btb_hit !== 1'b0) $display("FAIL reset_cold_miss: hit=%b, expected 0", bus.btb_hit);
        else pass_cnt++;
    endtask

    task automatic test_jump();
        bit [31:0] pcs [2] = '{32'hdeadbe74, 32'hdeadbe78};
        bit        eh  [2] = '{1'b1, 1'b0};
        bit [31:0] ea  [2] = '{32'hcafecafc, 32'h0};
        drv_commit(1, 0, 0, 0, 32'hdeadbe74, 32'hcafecafc);
        for (int i = 0; i < 2; i++) begin
            bus.pc = pcs[i];
            @(negedge clk);
            chk_cnt++;
            if (bus.btb_hit !== eh[i] || bus.btb_addr !== ea[i])
                $display("FAIL jump_lookup pc=%h: hit=%b addr=%h, expected hit=%b addr=%h",
                         pcs[i], bus.btb_hit, bus.btb_addr, eh[i], ea[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_evict();
        bit [31:0] pcs [3] = '{32'hdeadbe74, 32'hdeadbef4, 32'hdeadbf74};
        bit        eh  [3] = '{1'b0, 1'b1, 1'b1};
        bit [31:0] ea  [3] = '{32'h0, 32'h0000b0b0, 32'h0000c0c0};
        drv_commit(1, 0, 0, 0, 32'hdeadbe74, 32'h0000a0a0);
        drv_commit(1, 0, 0, 0, 32'hdeadbef4, 32'h0000b0b0);
        drv_commit(1, 0, 0, 0, 32'hdeadbf74, 32'h0000c0c0);
        for (int i = 0; i < 3; i++) begin
            bus.pc = pcs[i];
            @(negedge clk);
            chk_cnt++;
            if (bus.btb_hit !== eh[i] || bus.btb_addr !== ea[i])
                $display("FAIL evict_lookup pc=%h: hit=%b addr=%h, expected hit=%b addr=%h",
                         pcs[i], bus.btb_hit, bus.btb_addr, eh[i], ea[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_counter();
        // Taken/not-taken sequence and the prediction expected after each step.
        bit        tk [6] = '{1, 0, 1, 1, 1, 0};
        bit        eh [6] = '{1, 0, 1, 1, 1, 1};
        bus.pc = 32'h00001000;
        for (int i = 0; i < 6; i++) begin
            drv_commit(0, 1, tk[i], 0, 32'h00001000, 32'h00002000);
            @(negedge clk);
            chk_cnt++;
            if (bus.btb_hit !== eh[i] || bus.btb_addr !== (eh[i] ? 32'h00002000 : 32'h0))
                $display("FAIL counter_step%0d: hit=%b addr=%h, expected hit=%b", i,
                         bus.btb_hit, bus.btb_addr, eh[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_br_miss();
        bus.pc = 32'h00001000;
        drv_commit(0, 1, 1, 1, 32'h00001000, 32'h12345678);
        @(negedge clk);
        chk_cnt++;
        if (bus.btb_hit !== 1'b1 || bus.btb_addr !== 32'h12345678)
            $display("FAIL br_miss_retarget: hit=%b addr=%h, expected hit=1 addr=12345678",
                     bus.btb_hit, bus.btb_addr);
        else pass_cnt++;
        // Not-taken miss in the same set must leave the entry alone.
        drv_commit(0, 1, 0, 0, 32'h20001000, 32'h0);
        @(negedge clk);
        chk_cnt++;
        if (bus.btb_hit !== 1'b1 || bus.btb_addr !== 32'h12345678)
            $display("FAIL br_nt_miss_nochange: hit=%b addr=%h, expected hit=1 addr=12345678",
                     bus.btb_hit, bus.btb_addr);
        else pass_cnt++;
        // Counter was reset to 2, so one not-taken drops below threshold.
        drv_commit(0, 1, 0, 0, 32'h00001000, 32'h0);
        @(negedge clk);
        chk_cnt++;
        if (bus.btb_hit !== 1'b0 || bus.btb_addr !== 32'h0)
            $display("FAIL br_miss_cnt: hit=%b addr=%h, expected hit=0 addr=0",
                     bus.btb_hit, bus.btb_addr);
        else pass_cnt++;
    endtask

    bit [31:0] pool [8] = '{32'h00001000, 32'h00001040, 32'h00001080, 32'h000010c4,
                            32'hdeadbe74, 32'hdeadbef4, 32'hdeadbf74, 32'h80000034};

    task automatic test_random();
        bit        eh, jc, bc, bt, bm;
        bit [31:0] ea, la, ca, ct;
        for (int i = 0; i < 400; i++) begin
            la = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            ca = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            ct = ($urandom_range(0, 3) == 0) ? $urandom : {28'h0, 4'($urandom_range(1, 3)), 2'b0};
            jc = ($urandom_range(0, 3) == 0);
            bc = $urandom_range(0, 1);
            bt = ($urandom_range(0, 2) != 0);
            bm = $urandom_range(0, 1);
            bus.pc           = la;
            bus.jump_commit_ = !jc;
            bus.jump_miss_   = $urandom_range(0, 1);
            bus.br_commit_   = !bc;
            bus.br_taken_    = !bt;
            bus.br_miss_     = !bm;
            bus.com_addr     = ca;
            bus.com_tar_addr = ct;
            @(negedge clk);
            m_lookup(la, eh, ea);
            chk_cnt++;
            if (bus.btb_hit !== eh || bus.btb_addr !== ea)
                $display("FAIL random_lookup it=%0d pc=%h: hit=%b addr=%h, expected hit=%b addr=%h",
                         i, la, bus.btb_hit, bus.btb_addr, eh, ea);
            else pass_cnt++;
            @(posedge clk);
            m_commit(jc, bc, bt, bm, ca, ct);
            #1;
        end
        release_inputs();
    endtask

    task automatic test_flush();
        int n;
        bit saw;
        drv_commit(1, 0, 0, 0, 32'hdeadbe74, 32'hcafecafc);
        bus.pc      = 32'hdeadbe74;
        bus.flush_  = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_  = 1'b1;
        n   = 0;
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.btb_busy) break;
            n++;
            if (bus.btb_hit !== 1'b0 || bus.btb_addr !== 32'h0) saw = 1;
            // Jump commit during the third busy cycle must be dropped.
            bus.jump_commit_ = (n == 3) ? 1'b0 : 1'b1;
            bus.com_addr     = 32'h00003000;
            bus.com_tar_addr = 32'h11111110;
            @(posedge clk);
            #1;
        end
        release_inputs();
        m_clear();
        chk_cnt++;
        if (n != 16) $display("FAIL flush_walk_len: busy cycles=%0d, expected 16", n);
        else pass_cnt++;
        chk_cnt++;
        if (saw) $display("FAIL flush_no_pred: prediction seen=1, expected 0");
        else pass_cnt++;
        for (int i = 0; i < 9; i++) begin
            bus.pc = (i == 8) ? 32'h00003000 : pool[i];
            @(negedge clk);
            chk_cnt++;
            if (bus.btb_hit !== 1'b0 || bus.btb_addr !== 32'h0)
                $display("FAIL flush_cleared pc=%h: hit=%b addr=%h, expected hit=0 addr=0",
                         bus.pc, bus.btb_hit, bus.btb_addr);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_walk();
        int n;
        bit saw;
        drv_commit(1, 0, 0, 0, 32'hdeadbe74, 32'hcafecafc);
        bus.flush_ = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_ = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_clear();
        count_busy(n, saw);
        chk_cnt++;
        if (n != 16) $display("FAIL reset_mid_walk_len: busy cycles=%0d, expected 16", n);
        else pass_cnt++;
        bus.pc = 32'hdeadbe74;
        @(negedge clk);
        chk_cnt++;
        if (bus.btb_hit !== 1'b0) $display("FAIL reset_mid_walk_clear: hit=%b, expected 0",
                                           bus.btb_hit);
        else pass_cnt++;
        drv_commit(1, 0, 0, 0, 32'hdeadbe74, 32'h0badc0de);
        @(negedge clk);
        chk_cnt++;
        if (bus.btb_hit !== 1'b1 || bus.btb_addr !== 32'h0badc0de)
            $display("FAIL post_walk_train: hit=%b addr=%h, expected hit=1 addr=0badc0de",
                     bus.btb_hit, bus.btb_addr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_evict();
        test_counter();
        test_br_miss();
        test_random();
        test_flush();
        test_reset_mid_walk();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
